div_issue_ctrl: RTL and testbench

- Initiator/consumer side of the AXI-stream divider used by the muldiv stage.
- Accepts one RV32M divide/remainder op from the pipeline and converts signed operands to magnitudes.
- Issues one launch to the unsigned divider, waits for its `dout`, then applies sign fix-up and RISC-V corner cases.
- Presents a 32-bit result on a valid/ready response port.

---
 rtl/div_issue_ctrl_if.sv | 17 +
 rtl/div_issue_ctrl.sv | 138 +++++++++++++
 tb/tb_div_issue_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: pipeline-side request/response handshake of the divide issue controller.
interface div_issue_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_err;
   modport master (output req_valid, req_op, req_rs1, req_rs2, flush, resp_ready,
                   input  req_ready, resp_valid, resp_data, resp_err);
   modport slave  (input  req_valid, req_op, req_rs1, req_rs2, flush, resp_ready,
                   output req_ready, resp_valid, resp_data, resp_err);
endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: launches RV32M div/rem magnitudes to an unsigned AXI-stream divider and sign-fixes the result.
// Optional watchdog on the divider wait is enabled by defining DIV_TIMEOUT_EN.
module div_issue_ctrl #(
   parameter int TIMEOUT_CYCLES = 32,
   parameter int CNT_W          = 8
) (
   input  logic                aclk,
   input  logic                aresetn,
   div_issue_ctrl_if.slave     bus,
   output logic [31:0]         m_axis_dividend_tdata,
   output logic                m_axis_dividend_tvalid,
   output logic [31:0]         m_axis_divisor_tdata,
   output logic                m_axis_divisor_tvalid,
   input  logic [63:0]         s_axis_dout_tdata,
   input  logic                s_axis_dout_tvalid
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, RESP} state_t;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic [31:0]      dvd_q, dvd_d, dvs_q, dvs_d, resp_data_q, resp_data_d;
   logic             launch_q, launch_d, req_ready_q, req_ready_d;
   logic             resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
   logic             dout_tvalid_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done, sgn, timeout;
   logic [31:0]      res_sel, res;
   assign done    = s_axis_dout_tvalid & ~dout_tvalid_q;
   assign sgn     = ~bus.req_op[0];
   assign res_sel = op_q[1] ? s_axis_dout_tdata[31:0] : s_axis_dout_tdata[63:32];
   assign res     = (op_q[1] ? neg_rem_q : neg_quo_q) ? -res_sel : res_sel;
`ifdef DIV_TIMEOUT_EN
   assign timeout = cnt_q == CNT_MAX;
`else
   assign timeout = 1'b0;
`endif
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      neg_quo_d    = neg_quo_q;
      neg_rem_d    = neg_rem_q;
      dvd_d        = dvd_q;
      dvs_d        = dvs_q;
      resp_data_d  = resp_data_q;
      launch_d     = 1'b0;
      req_ready_d  = req_ready_q;
      resp_valid_d = resp_valid_q;
      resp_err_d   = resp_err_q;
      cnt_d        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      case (state_q)
         IDLE: if (bus.req_valid && !bus.flush) begin
            op_d        = bus.req_op;
            neg_quo_d   = sgn & (bus.req_rs1[31] ^ bus.req_rs2[31]);
            neg_rem_d   = sgn & bus.req_rs1[31];
            req_ready_d = 1'b0;
            resp_err_d  = 1'b0;
            if (bus.req_rs2 == '0) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_data_d  = bus.req_op[1] ? bus.req_rs1 : '1;
            end else begin
               state_d  = ISSUE;
               launch_d = 1'b1;
               dvd_d    = (sgn && bus.req_rs1[31]) ? -bus.req_rs1 : bus.req_rs1;
               dvs_d    = (sgn && bus.req_rs2[31]) ? -bus.req_rs2 : bus.req_rs2;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = bus.flush ? DRAIN : WAIT;
         end
         WAIT: if (bus.flush) begin
            // A done arriving with the flush has nothing left to drain.
            state_d     = done ? IDLE : DRAIN;
            req_ready_d = done;
         end else if (done) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = res;
         end else if (timeout) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = '0;
            resp_err_d   = 1'b1;
         end
         DRAIN: if (done || timeout) begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
         RESP: if (bus.flush || bus.resp_ready) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
            req_ready_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q       <= IDLE;
         op_q          <= '0;
         neg_quo_q     <= 1'b0;
         neg_rem_q     <= 1'b0;
         dvd_q         <= '0;
         dvs_q         <= '0;
         resp_data_q   <= '0;
         launch_q      <= 1'b0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_err_q    <= 1'b0;
         cnt_q         <= '0;
         dout_tvalid_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         neg_quo_q     <= neg_quo_d;
         neg_rem_q     <= neg_rem_d;
         dvd_q         <= dvd_d;
         dvs_q         <= dvs_d;
         resp_data_q   <= resp_data_d;
         launch_q      <= launch_d;
         req_ready_q   <= req_ready_d;
         resp_valid_q  <= resp_valid_d;
         resp_err_q    <= resp_err_d;
         cnt_q         <= cnt_d;
         dout_tvalid_q <= s_axis_dout_tvalid;
      end
   end
   assign m_axis_dividend_tdata  = dvd_q;
   assign m_axis_divisor_tdata   = dvs_q;
   assign m_axis_dividend_tvalid = launch_q;
   assign m_axis_divisor_tvalid  = launch_q;
   assign bus.req_ready          = req_ready_q;
   assign bus.resp_valid         = resp_valid_q;
   assign bus.resp_data          = resp_data_q;
   assign bus.resp_err           = resp_err_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed vectors for div_issue_ctrl against a fixed-latency unsigned divider stub.
module tb_div_issue_ctrl;
   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [31:0] dvd_tdata, dvs_tdata;
   logic        dvd_tvalid, dvs_tvalid;
   logic [63:0] dout_tdata = '0;
   logic        dout_tvalid = 1'b1;
   int          vecs = 0, errs = 0;
   int          launches = 0, pulse_cycles = 0, strobe_diff = 0, dcnt = 0;
   logic [31:0] cap_a = '0, cap_b = '0;
   bit          pend = 1'b0, stub_en = 1'b1;
   div_issue_ctrl_if bus();
   div_issue_ctrl dut (
      .aclk(aclk), .aresetn(aresetn), .bus(bus),
      .m_axis_dividend_tdata(dvd_tdata), .m_axis_dividend_tvalid(dvd_tvalid),
      .m_axis_divisor_tdata(dvs_tdata), .m_axis_divisor_tvalid(dvs_tvalid),
      .s_axis_dout_tdata(dout_tdata), .s_axis_dout_tvalid(dout_tvalid)
   );
   always #5 aclk = ~aclk;
   // Divider stub: latches on the strobe, answers 8 cycles later, holds tvalid until the next launch.
   always @(posedge aclk) begin
      if (dvs_tvalid !== dvd_tvalid) strobe_diff <= strobe_diff + 1;
      if (dvd_tvalid) begin
         dout_tvalid  <= 1'b0;
         pend         <= 1'b1;
         dcnt         <= 8;
         cap_a        <= dvd_tdata;
         cap_b        <= dvs_tdata;
         launches     <= launches + 1;
         pulse_cycles <= pulse_cycles + 1;
      end else if (pend && stub_en) begin
         if (dcnt == 0) begin
            dout_tvalid <= 1'b1;
            dout_tdata  <= {cap_a / cap_b, cap_a % cap_b};
            pend        <= 1'b0;
         end else dcnt <= dcnt - 1;
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
      @(negedge aclk);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_rs1   = a;
      bus.req_rs2   = b;
      bus.flush     = fl;
      @(posedge aclk);
      #1;
      bus.req_valid = 1'b0;
      bus.flush     = 1'b0;
   endtask
   task automatic wait_resp(output bit got);
      got = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (bus.resp_valid) begin
            got = 1'b1;
            break;
         end
         @(posedge aclk);
         #1;
      end
   endtask
   task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic launch, input logic [31:0] ea,
                        input logic [31:0] eb, input int hold);
      int l0, p0;
      bit got;
      l0 = launches;
      p0 = pulse_cycles;
      send(op, a, b, 1'b0);
      chk({tag, " req_ready_low"}, 32'(bus.req_ready), 32'd0);
      wait_resp(got);
      chk({tag, " resp_seen"}, 32'(got), 32'd1);
      chk({tag, " resp_data"}, bus.resp_data, exp);
      chk({tag, " resp_err"}, 32'(bus.resp_err), 32'd0);
      chk({tag, " launches"}, 32'(launches - l0), 32'(launch));
      chk({tag, " pulse_cycles"}, 32'(pulse_cycles - p0), 32'(launch));
      if (launch) begin
         chk({tag, " dividend"}, cap_a, ea);
         chk({tag, " divisor"}, cap_b, eb);
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge aclk);
         #1;
         chk({tag, " hold_valid"}, 32'(bus.resp_valid), 32'd1);
         chk({tag, " hold_data"}, bus.resp_data, exp);
      end
      @(negedge aclk);
      bus.resp_ready = 1'b1;
      @(posedge aclk);
      #1;
      bus.resp_ready = 1'b0;
      chk({tag, " req_ready_back"}, 32'(bus.req_ready), 32'd1);
      chk({tag, " resp_valid_clr"}, 32'(bus.resp_valid), 32'd0);
   endtask
   initial begin
      int  l0, p0;
      bit  got, saw;
      bus.req_valid  = 1'b0;
      bus.req_op     = 2'b00;
      bus.req_rs1    = '0;
      bus.req_rs2    = '0;
      bus.flush      = 1'b0;
      bus.resp_ready = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      chk("rst req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst resp_data", bus.resp_data, 32'd0);
      chk("rst resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst tvalid", 32'(dvd_tvalid), 32'd0);
      chk("rst dividend", dvd_tdata, 32'd0);
      chk("rst divisor", dvs_tdata, 32'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      chk("stale done ignored", 32'(bus.resp_valid), 32'd0);
      do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 1'b1, 32'd100, 32'd7, 0);
      do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b1, 32'd100, 32'd7, 0);
      do_op("div_m100_7", 2'b00, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b1, 32'd100, 32'd7, 0);
      do_op("rem_m100_7", 2'b10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 1'b1, 32'd100, 32'd7, 0);
      do_op("div_100_m7", 2'b00, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b1, 32'd100, 32'd7, 0);
      do_op("rem_100_m7", 2'b10, 32'd100, 32'hFFFFFFF9, 32'd2, 1'b1, 32'd100, 32'd7, 0);
      do_op("div_m100_m7", 2'b00, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 1'b1, 32'd100, 32'd7, 0);
      do_op("rem_m100_m7", 2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd100, 32'd7, 0);
      do_op("divu_big_7", 2'b01, 32'hFFFFFF9C, 32'd7, 32'h24924916, 1'b1, 32'hFFFFFF9C, 32'd7, 0);
      do_op("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 32'h80000000, 32'd1, 0);
      do_op("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1, 32'h80000000, 32'd1, 0);
      do_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0, 0);
      do_op("rem_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 0);
      do_op("div_m100_0", 2'b00, 32'hFFFFFF9C, 32'd0, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0, 0);
      do_op("rem_m100_0", 2'b10, 32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C, 1'b0, 32'd0, 32'd0, 0);
      do_op("hold_divu", 2'b01, 32'd1000, 32'd3, 32'd333, 1'b1, 32'd1000, 32'd3, 10);
      // Flush three cycles into WAIT: result is discarded and req_ready waits for the done edge.
      send(2'b01, 32'd1000, 32'd10, 1'b0);
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      bus.flush = 1'b1;
      @(posedge aclk);
      #1;
      bus.flush = 1'b0;
      chk("flush req_ready_low", 32'(bus.req_ready), 32'd0);
      chk("flush done_pending", 32'(dout_tvalid), 32'd0);
      got = 1'b0;
      saw = 1'b0;
      for (int n = 0; n < 100; n++) begin
         if (bus.resp_valid) saw = 1'b1;
         if (bus.req_ready) begin
            got = 1'b1;
            break;
         end
         @(posedge aclk);
         #1;
      end
      chk("flush ready_returns", 32'(got), 32'd1);
      chk("flush no_resp", 32'(saw), 32'd0);
      chk("flush done_seen", 32'(dout_tvalid), 32'd1);
      do_op("after_flush", 2'b00, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b1, 32'd100, 32'd7, 0);
      l0 = launches;
      p0 = pulse_cycles;
      send(2'b01, 32'd9, 32'd3, 1'b1);
      chk("idle_flush req_ready", 32'(bus.req_ready), 32'd1);
      repeat (3) @(posedge aclk);
      #1;
      chk("idle_flush no_resp", 32'(bus.resp_valid), 32'd0);
      chk("idle_flush no_launch", 32'(pulse_cycles - p0), 32'd0);
      send(2'b01, 32'd9, 32'd0, 1'b0);
      chk("resp_flush valid", 32'(bus.resp_valid), 32'd1);
      @(negedge aclk);
      bus.flush = 1'b1;
      @(posedge aclk);
      #1;
      bus.flush = 1'b0;
      chk("resp_flush dropped", 32'(bus.resp_valid), 32'd0);
      chk("resp_flush req_ready", 32'(bus.req_ready), 32'd1);
      send(2'b01, 32'd50, 32'd5, 1'b0);
      repeat (3) @(posedge aclk);
      #1;
      aresetn = 1'b0;
      #1;
      chk("midreset req_ready", 32'(bus.req_ready), 32'd1);
      chk("midreset tvalid", 32'(dvd_tvalid), 32'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      repeat (20) @(posedge aclk);
      #1;
      chk("midreset no_resp", 32'(bus.resp_valid), 32'd0);
      do_op("after_reset", 2'b11, 32'd50, 32'd7, 32'd1, 1'b1, 32'd50, 32'd7, 0);
      chk("strobes identical", 32'(strobe_diff), 32'd0);
`ifdef DIV_TIMEOUT_EN
      stub_en = 1'b0;
      send(2'b01, 32'd9, 32'd3, 1'b0);
      wait_resp(got);
      chk("timeout resp_seen", 32'(got), 32'd1);
      chk("timeout resp_err", 32'(bus.resp_err), 32'd1);
      chk("timeout resp_data", bus.resp_data, 32'd0);
      @(negedge aclk);
      bus.resp_ready = 1'b1;
      @(posedge aclk);
      #1;
      bus.resp_ready = 1'b0;
      stub_en = 1'b1;
      repeat (12) @(posedge aclk);
      #1;
      chk("timeout stale_done_ignored", 32'(bus.resp_valid), 32'd0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
